// File: rtl/matrix_key_scanner.sv
// rtl/matrix_key_scanner.sv - 4x4 active-low key matrix scanner with frame-level debounce.
// Drives one row low at a time, collects a 16-key frame, and emits one event per accepted press.
module matrix_key_scanner #(
  parameter int SCAN_CYCLES     = 50000,
  parameter int DEBOUNCE_FRAMES = 10
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_col_in,
  output logic [3:0] o_row_out,
  output logic       o_key_valid,
  output logic [3:0] o_key_code,
  output logic       o_key_held
);

  localparam int            CW         = $clog2(SCAN_CYCLES);
  localparam logic [CW-1:0] DWELL_LAST = CW'(SCAN_CYCLES - 1);
  localparam logic [7:0]    DEB_FRAMES = 8'(DEBOUNCE_FRAMES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS,
    S_HELD,
    S_RELEASE
  } state_t;

  logic [3:0]    r_col_meta;
  logic [3:0]    r_col_sync;
  logic [1:0]    r_row;
  logic [CW-1:0] r_dwell;
  logic [3:0]    r_row_out;
  logic [11:0]   r_acc;

  state_t        r_state;
  state_t        w_state_nx;
  logic [7:0]    r_cnt;
  logic [7:0]    w_cnt_nx;
  logic [7:0]    w_cnt_inc;
  logic [3:0]    r_cand;
  logic [3:0]    w_cand_nx;
  logic          r_valid;
  logic          w_valid_nx;
  logic [3:0]    r_code;
  logic [3:0]    w_code_nx;
  logic          r_held;
  logic          w_held_nx;

  logic          w_sample;
  logic          w_frame_end;
  logic [1:0]    w_row_nx;
  logic [15:0]   w_frame;
  logic          w_none;
  logic          w_single;
  logic [3:0]    w_single_code;

  assign w_sample    = (r_dwell == DWELL_LAST);
  assign w_frame_end = w_sample && (r_row == 2'd3);
  assign w_row_nx    = r_row + 2'd1;
  // Row 3 is never stored: it is folded in directly from the synchronizer at frame end.
  assign w_frame     = {~r_col_sync, r_acc};
  assign w_none      = (w_frame == 16'h0000);
  assign w_single    = !w_none && ((w_frame & (w_frame - 16'd1)) == 16'h0000);
  assign w_cnt_inc   = r_cnt + 8'd1;

  always_comb begin
    w_single_code = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (w_frame[i]) w_single_code = 4'(i);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_col_meta <= 4'hF;
      r_col_sync <= 4'hF;
      r_row      <= 2'd0;
      r_dwell    <= '0;
      r_row_out  <= 4'b1110;
      r_acc      <= 12'h000;
    end else begin
      r_col_meta <= i_col_in;
      r_col_sync <= r_col_meta;
      if (w_sample) begin
        r_dwell   <= '0;
        r_row     <= w_row_nx;
        r_row_out <= ~(4'b0001 << w_row_nx);
        case (r_row)
          2'd0:    r_acc[3:0]  <= ~r_col_sync;
          2'd1:    r_acc[7:4]  <= ~r_col_sync;
          2'd2:    r_acc[11:8] <= ~r_col_sync;
          default: r_acc       <= 12'h000;
        endcase
      end else begin
        r_dwell <= r_dwell + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
      r_cand  <= 4'h0;
      r_valid <= 1'b0;
      r_code  <= 4'h0;
      r_held  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_cand  <= w_cand_nx;
      r_valid <= w_valid_nx;
      r_code  <= w_code_nx;
      r_held  <= w_held_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_cand_nx  = r_cand;
    w_valid_nx = 1'b0;
    w_code_nx  = r_code;
    w_held_nx  = r_held;
    if (w_frame_end) begin
      case (r_state)
        S_IDLE: begin
          if (w_single) begin
            w_cand_nx  = w_single_code;
            w_cnt_nx   = 8'd1;
            w_state_nx = S_PRESS;
          end
        end
        S_PRESS: begin
          if (w_single && (w_single_code == r_cand)) begin
            w_cnt_nx = w_cnt_inc;
            if (w_cnt_inc == DEB_FRAMES) begin
              w_valid_nx = 1'b1;
              w_code_nx  = r_cand;
              w_held_nx  = 1'b1;
              w_state_nx = S_HELD;
            end
          end else if (w_single) begin
            w_cand_nx = w_single_code;
            w_cnt_nx  = 8'd1;
          end else begin
            w_cnt_nx   = 8'd0;
            w_state_nx = S_IDLE;
          end
        end
        S_HELD: begin
          if (w_none) begin
            w_cnt_nx   = 8'd1;
            w_state_nx = S_RELEASE;
          end
        end
        default: begin
          // A press seen mid-release is a bounce on the same hold, never a new event.
          if (w_none) begin
            w_cnt_nx = w_cnt_inc;
            if (w_cnt_inc == DEB_FRAMES) begin
              w_held_nx  = 1'b0;
              w_state_nx = S_IDLE;
            end
          end else begin
            w_state_nx = S_HELD;
          end
        end
      endcase
    end
  end

  assign o_row_out   = r_row_out;
  assign o_key_valid = r_valid;
  assign o_key_code  = r_code;
  assign o_key_held  = r_held;

endmodule

// File: tb/tb_matrix_key_scanner.sv
// tb/tb_matrix_key_scanner.sv - bench for matrix_key_scanner with a frame-level key model.
module tb_matrix_key_scanner;

  localparam int SC = 8;
  localparam int DF = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  col;
  logic [3:0]  row;
  logic        valid;
  logic [3:0]  code;
  logic        held;
  logic [15:0] keys = 16'h0000;

  always #5 clk = ~clk;

  matrix_key_scanner #(.SCAN_CYCLES(SC), .DEBOUNCE_FRAMES(DF)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_col_in    (col),
    .o_row_out   (row),
    .o_key_valid (valid),
    .o_key_code  (code),
    .o_key_held  (held)
  );

  // Physical matrix: a pressed key pulls its column low while its row is driven low.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row[r] && keys[r*4+c]) col[c] = 1'b0;
  end

  int n_tests = 0;
  int n_fail  = 0;

  int          p;
  logic [15:0] k1, k2, acc;
  bit          m_held;
  int          run_key, run_len, none_run;
  logic        exp_valid;
  logic [3:0]  exp_code, exp_row;

  int          ev_cyc[$];
  int          ev_code[$];
  int          last_fall = -1;
  logic        prev_held = 1'b0;
  logic [3:0]  row_at [0:40];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, p, got, want);
    end
  endtask

  // Model: a press is accepted after DF consecutive frames showing the same lone key,
  // a release after DF consecutive empty frames; anything else restarts the run.
  always @(posedge clk) begin
    if (!rst_n) begin
      p = 0; k1 = '0; k2 = '0; acc = '0;
      m_held = 0; run_key = 0; run_len = 0; none_run = 0;
      exp_valid = 1'b0; exp_code = 4'h0; exp_row = 4'b1110;
    end else begin
      p++;
      exp_valid = 1'b0;
      if (p % SC == 0) begin
        int r;
        r = ((p / SC) - 1) % 4;
        acc[r*4 +: 4] = k2[r*4 +: 4];
        if (r == 3) begin
          int ones, k;
          ones = $countones(acc);
          k = 0;
          for (int i = 0; i < 16; i++) if (acc[i]) k = i;
          if (!m_held) begin
            if (ones == 1) begin
              if (run_len > 0 && k == run_key) run_len++;
              else begin run_key = k; run_len = 1; end
              if (run_len == DF) begin
                exp_valid = 1'b1; exp_code = 4'(k); m_held = 1; none_run = 0; run_len = 0;
              end
            end else run_len = 0;
          end else begin
            if (ones == 0) begin
              none_run++;
              if (none_run == DF) begin m_held = 0; none_run = 0; end
            end else none_run = 0;
          end
          acc = '0;
        end
      end
      exp_row = ~(4'b0001 << ((p / SC) % 4));
      k2 = k1;
      k1 = keys;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset_outputs", 32'({row, valid, code, held}), 32'({4'b1110, 1'b0, 4'h0, 1'b0}));
      prev_held = 1'b0;
    end else begin
      check("row_valid_code_held", 32'({row, valid, code, held}),
            32'({exp_row, exp_valid, exp_code, m_held}));
      if (valid) begin ev_cyc.push_back(p); ev_code.push_back(int'(code)); end
      if (prev_held && !held) last_fall = p;
      prev_held = held;
      if (p <= 40) row_at[p] = row;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input logic [15:0] k);
    @(posedge clk); #2;
    rst_n = 1'b0;
    keys  = k;
    repeat (2) @(posedge clk); #2;
    ev_cyc.delete();
    ev_code.delete();
    last_fall = -1;
    rst_n = 1'b1;
  endtask

  function automatic int first_cyc();
    return (ev_cyc.size() > 0) ? ev_cyc[0] : -1;
  endfunction

  function automatic int first_code();
    return (ev_code.size() > 0) ? ev_code[0] : -1;
  endfunction

  initial begin
    repeat (3) @(posedge clk); #2;
    check("rst_row", 32'(row), 32'(4'b1110));
    check("rst_valid_held_code", 32'({valid, held, code}), 32'h0);
    rst_n = 1'b1;
    wait_cyc(40);
    check("scan_row_c1", 32'(row_at[1]), 32'(4'b1110));
    check("scan_row_c8", 32'(row_at[8]), 32'(4'b1101));
    check("scan_row_c16", 32'(row_at[16]), 32'(4'b1011));
    check("scan_row_c24", 32'(row_at[24]), 32'(4'b0111));
    check("scan_row_c32", 32'(row_at[32]), 32'(4'b1110));

    // Clean press of key (2,1) = 9, held 20 frames.
    do_reset(16'h0200);
    wait_cyc(640);
    check("clean_held_high", 32'(held), 32'd1);
    keys = 16'h0000;
    wait_cyc(160);
    check("clean_events", ev_cyc.size(), 32'd1);
    check("clean_cycle", first_cyc(), 32'd96);
    check("clean_code", first_code(), 32'd9);
    check("clean_fall", last_fall, 32'd736);

    // Key 5 bouncing every 20 cycles, stable from cycle 160.
    do_reset(16'h0020);
    for (int i = 0; i < 8; i++) begin
      wait_cyc(20);
      keys = keys ^ 16'h0020;
    end
    wait_cyc(140);
    check("bounce_events", ev_cyc.size(), 32'd1);
    check("bounce_cycle", first_cyc(), 32'd256);
    check("bounce_code", first_code(), 32'd5);
    keys = 16'h0000;
    wait_cyc(160);

    // Chord of keys 0 and 15, then key 0 released.
    do_reset(16'h8001);
    wait_cyc(256);
    check("chord_no_event", ev_cyc.size(), 32'd0);
    keys = 16'h8000;
    wait_cyc(144);
    check("chord_events", ev_cyc.size(), 32'd1);
    check("chord_cycle", first_cyc(), 32'd352);
    check("chord_code", first_code(), 32'd15);
    keys = 16'h0000;
    wait_cyc(160);

    // Key 3 released for one frame then re-pressed, then finally released.
    do_reset(16'h0008);
    wait_cyc(320);
    keys = 16'h0000;
    wait_cyc(32);
    keys = 16'h0008;
    wait_cyc(96);
    check("refilter_held", 32'(held), 32'd1);
    check("refilter_events", ev_cyc.size(), 32'd1);
    check("refilter_cycle", first_cyc(), 32'd96);
    check("refilter_code", first_code(), 32'd3);
    keys = 16'h0000;
    wait_cyc(128);
    check("refilter_fall", last_fall, 32'd544);
    check("refilter_held_low", 32'(held), 32'd0);
    check("refilter_events_end", ev_cyc.size(), 32'd1);

    // Key 7 partially debounced, reset mid-dwell, then debounced afresh.
    do_reset(16'h0080);
    wait_cyc(84);
    check("press_no_event_yet", ev_cyc.size(), 32'd0);
    check("press_row_before", 32'(row), 32'(4'b1011));
    rst_n = 1'b0;
    #1;
    check("midrst_row", 32'(row), 32'(4'b1110));
    check("midrst_valid_held_code", 32'({valid, held, code}), 32'h0);
    repeat (2) @(posedge clk); #2;
    ev_cyc.delete();
    ev_code.delete();
    last_fall = -1;
    rst_n = 1'b1;
    wait_cyc(200);
    check("midrst_events", ev_cyc.size(), 32'd1);
    check("midrst_cycle", first_cyc(), 32'd96);
    check("midrst_code", first_code(), 32'd7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
